flags_ctrl: RTL and testbench

- Sequences the matmul overflow/underflow flags register across one matmul run.
- During the run it accumulates per-PE flag pulses from the PE array into a sticky vector (one bit per matrix square).
- On run completion or timeout it commits that vector to the flags register through a write-enable/write-data pair.
- Also services host clear requests, and arbitrates the single register write port between commit and clear.

---
 rtl/flags_ctrl.sv | 121 ++++++++++++
 tb/tb_flags_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/flags_ctrl.sv
// flags_ctrl: sequences the matmul overflow/underflow flags register across one run.
// Optional FLAGS_CTRL_ACCUM_EN: each commit also merges the previously committed vector.
//
// state  | meaning
// IDLE   | waiting for start_i or clear_i
// RUN    | accumulating PE flag pulses, counting cycles
// COMMIT | one-cycle write of the accumulated vector
// CLEAR  | one-cycle write of zero
module flags_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_WIDTH      = 64,
    parameter int MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           pe_valid_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]     pe_flags_i,
    input  logic                           done_i,
    input  logic                           clear_i,
    output logic                           busy_o,
    output logic                           flags_we_o,
    output logic [MAX_DIM*MAX_DIM-1:0]     flags_wdata_o,
    output logic                           any_flag_o,
    output logic                           timeout_o,
    output logic [CNT_W-1:0]               run_cnt_o
);

    localparam int FLAG_W = MAX_DIM * MAX_DIM;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, COMMIT, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [FLAG_W-1:0]  acc_q, acc_nxt, wdata_q, commit_vec;
    logic [CNT_W-1:0]   run_cnt_q;
    logic               any_q, timeout_q;
    logic               hit_timeout;

    assign acc_nxt     = pe_valid_i ? (acc_q | pe_flags_i) : acc_q;
    assign hit_timeout = !done_i && (run_cnt_q == TO_LAST);

`ifdef FLAGS_CTRL_ACCUM_EN
    // wdata_q always holds the last written vector and CLEAR writes zero, so it is the shadow
    assign commit_vec = acc_nxt | wdata_q;
`else
    assign commit_vec = acc_nxt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_i)      state_d = CLEAR;
                else if (start_i) state_d = RUN;
            end
            RUN: begin
                if (done_i || run_cnt_q == TO_LAST) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        flags_we_o = (state_q == COMMIT) || (state_q == CLEAR);
    end

    // The counter holds on the timeout edge so it reads TIMEOUT_CYCLES-1 after a forced commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            run_cnt_q <= '0;
            wdata_q   <= '0;
            any_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        wdata_q <= '0;
                    end else if (start_i) begin
                        acc_q     <= '0;
                        run_cnt_q <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    if (!hit_timeout && run_cnt_q != '1) run_cnt_q <= run_cnt_q + 1'b1;
                    if (done_i || hit_timeout) wdata_q <= commit_vec;
                    if (hit_timeout) timeout_q <= 1'b1;
                end
                COMMIT: begin
                    any_q <= |wdata_q;
                end
                CLEAR: begin
                    acc_q     <= '0;
                    any_q     <= 1'b0;
                    timeout_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign flags_wdata_o = wdata_q;
    assign any_flag_o    = any_q;
    assign timeout_o     = timeout_q;
    assign run_cnt_o     = run_cnt_q;

endmodule

// File: tb/tb_flags_ctrl.sv
// tb_flags_ctrl: directed and randomized checks of flags_ctrl against a run-level reference model.
module tb_flags_ctrl;
    localparam int FW = 4;
    localparam int T  = 8;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0, pe_valid_i = 1'b0, done_i = 1'b0, clear_i = 1'b0;
    logic [FW-1:0] pe_flags_i = '0;
    logic          busy_o, flags_we_o, any_flag_o, timeout_o;
    logic [FW-1:0] flags_wdata_o;
    logic [CW-1:0] run_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int we_count = 0;
    int consec = 0;
    logic we_prev = 1'b0;

    logic [FW-1:0] m_reg = '0;   // last vector written to the flags register

    flags_ctrl #(.DATA_WIDTH(32), .BUS_WIDTH(64), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pe_valid_i(pe_valid_i),
        .pe_flags_i(pe_flags_i), .done_i(done_i), .clear_i(clear_i), .busy_o(busy_o),
        .flags_we_o(flags_we_o), .flags_wdata_o(flags_wdata_o), .any_flag_o(any_flag_o),
        .timeout_o(timeout_o), .run_cnt_o(run_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (flags_we_o === 1'b1) begin
            we_count++;
            if (we_prev) consec++;
        end
        we_prev = (flags_we_o === 1'b1);
    end

    function automatic logic [FW-1:0] merged(input logic [FW-1:0] a);
`ifdef FLAGS_CTRL_ACCUM_EN
        return a | m_reg;
`else
        return a;
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [FW-1:0] f, input logic d);
        pe_valid_i = v; pe_flags_i = f; done_i = d;
        step();
        pe_valid_i = 1'b0; pe_flags_i = '0; done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        we_count = 0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (flags_wdata_o !== 4'b0) begin n_bad++; $display("FAIL reset_wdata: got %b want 0000", flags_wdata_o); end
        n_cmp++; if ({any_flag_o, timeout_o} !== 2'b00) begin n_bad++; $display("FAIL reset_any_to: got %b want 00", {any_flag_o, timeout_o}); end
        n_cmp++; if (run_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", run_cnt_o); end
        n_cmp++; if (we_count !== 0) begin n_bad++; $display("FAIL reset_we: got %0d pulses want 0", we_count); end
    endtask

    task automatic test_main();
        int base;
        logic [FW-1:0] exp;
        base = we_count;
        drive(1'b1, 4'b0010, 1'b1);   // ignored while IDLE
        n_cmp++; if (busy_o !== 1'b0 || we_count != base) begin n_bad++; $display("FAIL idle_ignore: busy %b pulses %0d want 0 0", busy_o, we_count - base); end
        start_i = 1'b1; step(); start_i = 1'b0;
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL main_busy: got %b want 1", busy_o); end
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0100, 1'b0);
        drive(1'b1, 4'b1000, 1'b1);
        exp = merged(4'b1101);
        n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== exp) begin n_bad++; $display("FAIL main_commit: we %b wdata %b want 1 %b", flags_we_o, flags_wdata_o, exp); end
        step();
        m_reg = exp;
        n_cmp++; if (busy_o !== 1'b0 || any_flag_o !== 1'b1 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL main_status: busy %b any %b to %b want 0 1 0", busy_o, any_flag_o, timeout_o); end
        n_cmp++; if (run_cnt_o !== 16'd3) begin n_bad++; $display("FAIL main_cnt: got %0d want 3", run_cnt_o); end
        n_cmp++; if (we_count - base !== 1 || flags_wdata_o !== exp) begin n_bad++; $display("FAIL main_once: pulses %0d wdata %b want 1 %b", we_count - base, flags_wdata_o, exp); end
    endtask

    task automatic test_timeout();
        int base;
        logic [FW-1:0] exp;
        base = we_count;
        start_i = 1'b1; step(); start_i = 1'b0;
        for (int c = 1; c < T; c++) drive(1'b0, 4'b0000, 1'b0);
        n_cmp++; if (busy_o !== 1'b1 || flags_we_o !== 1'b0) begin n_bad++; $display("FAIL to_early: busy %b we %b want 1 0", busy_o, flags_we_o); end
        drive(1'b1, 4'b0100, 1'b0);
        exp = merged(4'b0100);
        n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== exp) begin n_bad++; $display("FAIL to_commit: we %b wdata %b want 1 %b", flags_we_o, flags_wdata_o, exp); end
        step();
        m_reg = exp;
        n_cmp++; if (timeout_o !== 1'b1 || run_cnt_o !== 16'(T - 1)) begin n_bad++; $display("FAIL to_status: to %b cnt %0d want 1 %0d", timeout_o, run_cnt_o, T - 1); end
        drive(1'b0, 4'b0000, 1'b1);
        step();
        n_cmp++; if (we_count - base !== 1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL to_late_done: pulses %0d busy %b want 1 0", we_count - base, busy_o); end
    endtask

    task automatic test_clear_start();
        int base;
        base = we_count;
        start_i = 1'b1; clear_i = 1'b1; step(); start_i = 1'b0; clear_i = 1'b0;
        n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== 4'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL clr_write: we %b wdata %b busy %b want 1 0000 1", flags_we_o, flags_wdata_o, busy_o); end
        step();
        m_reg = '0;
        n_cmp++; if (busy_o !== 1'b0 || any_flag_o !== 1'b0 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL clr_status: busy %b any %b to %b want 0 0 0", busy_o, any_flag_o, timeout_o); end
        step();
        n_cmp++; if (busy_o !== 1'b0 || we_count - base !== 1) begin n_bad++; $display("FAIL clr_norun: busy %b pulses %0d want 0 1", busy_o, we_count - base); end
    endtask

    task automatic test_clear_in_run();
        int base;
        logic [FW-1:0] exp;
        base = we_count;
        start_i = 1'b1; step(); start_i = 1'b0;
        clear_i = 1'b1; drive(1'b1, 4'b0010, 1'b0); clear_i = 1'b0;
        drive(1'b0, 4'b1111, 1'b0);
        drive(1'b0, 4'b0000, 1'b1);
        exp = merged(4'b0010);
        n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== exp) begin n_bad++; $display("FAIL clrrun_commit: we %b wdata %b want 1 %b", flags_we_o, flags_wdata_o, exp); end
        step(); step();
        m_reg = exp;
        n_cmp++; if (we_count - base !== 1 || flags_wdata_o !== exp || any_flag_o !== 1'b1) begin n_bad++; $display("FAIL clrrun_single: pulses %0d wdata %b any %b want 1 %b 1", we_count - base, flags_wdata_o, any_flag_o, exp); end
    endtask

    task automatic test_accum();
        logic [FW-1:0] want2;
        clear_i = 1'b1; step(); clear_i = 1'b0; step();
        m_reg = '0;
        start_i = 1'b1; step(); start_i = 1'b0;
        drive(1'b1, 4'b0001, 1'b1);
        n_cmp++; if (flags_wdata_o !== 4'b0001) begin n_bad++; $display("FAIL acc_run1: got %b want 0001", flags_wdata_o); end
        step();
        m_reg = 4'b0001;
        start_i = 1'b1; step(); start_i = 1'b0;
        drive(1'b1, 4'b0010, 1'b1);
`ifdef FLAGS_CTRL_ACCUM_EN
        want2 = 4'b0011;
`else
        want2 = 4'b0010;
`endif
        n_cmp++; if (flags_wdata_o !== want2) begin n_bad++; $display("FAIL acc_run2: got %b want %b", flags_wdata_o, want2); end
        step();
        m_reg = want2;
    endtask

    task automatic test_random();
        int len, cycles, base;
        bit ends_done;
        logic [FW-1:0] acc, exp;
        for (int it = 0; it < 24; it++) begin
            base = we_count;
            if ($urandom_range(0, 4) == 0) begin
                clear_i = 1'b1; start_i = $urandom_range(0, 1); step(); clear_i = 1'b0; start_i = 1'b0;
                n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== 4'b0) begin n_bad++; $display("FAIL rnd_clear: we %b wdata %b want 1 0000", flags_we_o, flags_wdata_o); end
                step();
                m_reg = '0;
                n_cmp++; if (busy_o !== 1'b0 || any_flag_o !== 1'b0 || timeout_o !== 1'b0) begin n_bad++; $display("FAIL rnd_clear_st: busy %b any %b to %b want 0 0 0", busy_o, any_flag_o, timeout_o); end
            end else begin
                len = $urandom_range(1, T);
                ends_done = ($urandom_range(0, 3) != 0);
                cycles = ends_done ? len : T;
                start_i = 1'b1; step(); start_i = 1'b0;
                n_cmp++; if (busy_o !== 1'b1 || run_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rnd_start: busy %b cnt %0d want 1 0", busy_o, run_cnt_o); end
                acc = '0;
                for (int c = 1; c <= cycles; c++) begin
                    logic v;
                    logic [FW-1:0] f;
                    v = $urandom_range(0, 1);
                    f = FW'($urandom);
                    if (v) acc = acc | f;
                    clear_i = ($urandom_range(0, 5) == 0);
                    start_i = ($urandom_range(0, 5) == 0);
                    drive(v, f, ends_done && c == len);
                    clear_i = 1'b0; start_i = 1'b0;
                end
                exp = merged(acc);
                n_cmp++; if (flags_we_o !== 1'b1 || flags_wdata_o !== exp) begin n_bad++; $display("FAIL rnd_commit[%0d]: we %b wdata %b want 1 %b", it, flags_we_o, flags_wdata_o, exp); end
                step();
                m_reg = exp;
                n_cmp++; if (busy_o !== 1'b0 || any_flag_o !== (|exp) || timeout_o !== !ends_done) begin n_bad++; $display("FAIL rnd_status[%0d]: busy %b any %b to %b want 0 %b %b", it, busy_o, any_flag_o, timeout_o, |exp, !ends_done); end
                n_cmp++; if (run_cnt_o !== 16'(ends_done ? len : T - 1) || we_count - base !== 1) begin n_bad++; $display("FAIL rnd_cnt[%0d]: cnt %0d pulses %0d want %0d 1", it, run_cnt_o, we_count - base, ends_done ? len : T - 1); end
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
        end
    endtask

    task automatic test_reset_mid_run();
        int base;
        base = we_count;
        start_i = 1'b1; step(); start_i = 1'b0;
        drive(1'b1, 4'b1010, 1'b0);
        drive(1'b1, 4'b0101, 1'b0);
        rst_i = 1'b1; step(); rst_i = 1'b0;
        m_reg = '0;
        n_cmp++; if ({busy_o, flags_we_o, any_flag_o, timeout_o} !== 4'b0 || flags_wdata_o !== 4'b0 || run_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rst_run: busy %b we %b any %b to %b wdata %b cnt %0d want all 0", busy_o, flags_we_o, any_flag_o, timeout_o, flags_wdata_o, run_cnt_o); end
        step(); step();
        n_cmp++; if (we_count - base !== 0) begin n_bad++; $display("FAIL rst_nowrite: pulses %0d want 0", we_count - base); end
    endtask

    initial begin
        test_reset();
        test_main();
        test_timeout();
        test_clear_start();
        test_clear_in_run();
        test_accum();
        test_random();
        test_reset_mid_run();
        n_cmp++; if (consec !== 0) begin n_bad++; $display("FAIL we_consecutive: got %0d back-to-back pulses want 0", consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
